// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the program-counter sequencer and the control decoder.
package pc_sequencer_pkg;

   localparam int unsigned DEF_ADDR_W      = 12;
   localparam int unsigned DEF_STACK_DEPTH = 8;

   localparam logic [2:0] JT_NONE  = 3'd0;
   localparam logic [2:0] JT_ZERO  = 3'd1;
   localparam logic [2:0] JT_NZERO = 3'd2;
   localparam logic [2:0] JT_COUT  = 3'd3;
   localparam logic [2:0] JT_NCOUT = 3'd4;
   localparam logic [2:0] JT_JMP   = 3'd5;
   localparam logic [2:0] JT_JSB   = 3'd6;
   localparam logic [2:0] JT_RET   = 3'd7;

endpackage

// File: rtl/ret_stack.sv
// Circular return-address stack; depth saturates at STACK_DEPTH and holds at 0.
module ret_stack #(
   parameter int unsigned ADDR_W      = 12,
   parameter int unsigned STACK_DEPTH = 8,
   localparam int unsigned PTR_W      = $clog2(STACK_DEPTH),
   localparam int unsigned DEPTH_W    = PTR_W + 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               push,
   input  logic               pop,
   input  logic [ADDR_W-1:0]  din,
   output logic [ADDR_W-1:0]  dout,
   output logic [DEPTH_W-1:0] depth
);

   logic [ADDR_W-1:0]  mem [STACK_DEPTH];
   logic [PTR_W-1:0]   ptr_q, ptr_d, top_idx;
   logic [DEPTH_W-1:0] depth_q, depth_d;

   // ptr_q is the next free slot; the top of stack sits just below it.
   assign top_idx = ptr_q - PTR_W'(1);
   assign dout    = mem[top_idx];
   assign depth   = depth_q;

   always_comb begin
      ptr_d   = ptr_q;
      depth_d = depth_q;
      if (push) begin
         ptr_d = ptr_q + PTR_W'(1);
         if (depth_q != DEPTH_W'(STACK_DEPTH)) depth_d = depth_q + DEPTH_W'(1);
      end else if (pop) begin
         ptr_d = top_idx;
         if (depth_q != '0) depth_d = depth_q - DEPTH_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q   <= '0;
         depth_q <= '0;
      end else begin
         ptr_q   <= ptr_d;
         depth_q <= depth_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[ptr_q] <= din;
   end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter with conditional branches, jumps and a subroutine return stack.
// PC_STACK_GUARD_EN: refuse jsb when full / ret when empty and flag a sticky stack_err.
module pc_sequencer
   import pc_sequencer_pkg::*;
#(
   parameter int unsigned ADDR_W      = DEF_ADDR_W,
   parameter int unsigned STACK_DEPTH = DEF_STACK_DEPTH,
   localparam int unsigned DEPTH_W    = $clog2(STACK_DEPTH) + 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [2:0]         jump_type,
   input  logic [ADDR_W-1:0]  target,
   input  logic               stall,
   input  logic               flag_we,
   input  logic               zero_in,
   input  logic               cout_in,
   output logic [ADDR_W-1:0]  pc,
   output logic [DEPTH_W-1:0] depth,
   output logic               stack_err
);

   logic [ADDR_W-1:0] pc_q, pc_d, pc_inc, ret_addr;
   logic              zero_q, cout_q;
   logic              push_req, pop_req, push_blk, pop_blk, push, pop;

   assign pc_inc = pc_q + ADDR_W'(1);
   assign pc     = pc_q;

`ifdef PC_STACK_GUARD_EN
   logic full, empty, err_q;

   assign full      = (depth == DEPTH_W'(STACK_DEPTH));
   assign empty     = (depth == '0);
   assign push_blk  = full;
   assign pop_blk   = empty;
   assign stack_err = err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                                 err_q <= 1'b0;
      else if (!stall && ((push_req && full) || (pop_req && empty))) err_q <= 1'b1;
   end
`else
   assign push_blk  = 1'b0;
   assign pop_blk   = 1'b0;
   assign stack_err = 1'b0;
`endif

   // Branch decisions use the registered flags only.
   always_comb begin
      pc_d     = pc_inc;
      push_req = 1'b0;
      pop_req  = 1'b0;
      unique case (jump_type)
         JT_NONE:  pc_d = pc_inc;
         JT_ZERO:  if (zero_q)  pc_d = target;
         JT_NZERO: if (!zero_q) pc_d = target;
         JT_COUT:  if (cout_q)  pc_d = target;
         JT_NCOUT: if (!cout_q) pc_d = target;
         JT_JMP:   pc_d = target;
         JT_JSB: begin
            push_req = 1'b1;
            if (!push_blk) pc_d = target;
         end
         JT_RET: begin
            pop_req = 1'b1;
            if (!pop_blk) pc_d = ret_addr;
         end
      endcase
   end

   assign push = push_req && !push_blk && !stall;
   assign pop  = pop_req && !pop_blk && !stall;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q   <= '0;
         zero_q <= 1'b0;
         cout_q <= 1'b0;
      end else if (!stall) begin
         pc_q <= pc_d;
         if (flag_we) begin
            zero_q <= zero_in;
            cout_q <= cout_in;
         end
      end
   end

   ret_stack #(
      .ADDR_W      (ADDR_W),
      .STACK_DEPTH (STACK_DEPTH)
   ) u_ret_stack (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .din   (pc_inc),
      .dout  (ret_addr),
      .depth (depth)
   );

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer; adapts expectations to PC_STACK_GUARD_EN.
module tb_pc_sequencer;

   localparam logic [2:0] J_NONE = 3'd0, J_ZERO = 3'd1, J_NZERO = 3'd2, J_COUT = 3'd3;
   localparam logic [2:0] J_NCOUT = 3'd4, J_JMP = 3'd5, J_JSB = 3'd6, J_RET = 3'd7;
`ifdef PC_STACK_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   typedef struct {
      logic [2:0]  jt;
      logic [11:0] tgt;
      logic        fwe, z, c, stl;
      logic [11:0] pc;
      logic [3:0]  dep;
      logic        err;
      string       name;
   } vec_t;

   typedef struct {
      logic [11:0] pc;
      logic [3:0]  dep;
      logic        err;
      string       name;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [2:0]  jump_type = '0;
   logic [11:0] target = '0;
   logic        stall = 1'b0, flag_we = 1'b0, zero_in = 1'b0, cout_in = 1'b0;
   logic [11:0] pc;
   logic [3:0]  depth;
   logic        stack_err;

   exp_t sb[$];
   int   vectors = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;

   pc_sequencer dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .jump_type (jump_type),
      .target    (target),
      .stall     (stall),
      .flag_we   (flag_we),
      .zero_in   (zero_in),
      .cout_in   (cout_in),
      .pc        (pc),
      .depth     (depth),
      .stack_err (stack_err)
   );

   function automatic vec_t mk(logic [2:0] jt, logic [11:0] tgt, logic fwe, logic z, logic c,
                               logic stl, logic [11:0] epc, logic [3:0] edep, logic eerr,
                               string name);
      vec_t v;
      v.jt = jt; v.tgt = tgt; v.fwe = fwe; v.z = z; v.c = c; v.stl = stl;
      v.pc = epc; v.dep = edep; v.err = eerr; v.name = name;
      return v;
   endfunction

   // Inputs change 1 time unit after the edge; outputs are sampled at the same point.
   task automatic apply(input vec_t v);
      jump_type = v.jt; target = v.tgt; flag_we = v.fwe;
      zero_in = v.z; cout_in = v.c; stall = v.stl;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      vec_t tv[$];
      exp_t e;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      sb.push_back('{12'h000, 4'd0, 1'b0, "reset_state"});
      e = sb.pop_front();
      vectors++;
      if ({pc, depth, stack_err} !== {e.pc, e.dep, e.err}) begin
         miscompares++;
         $display("FAIL %s: got pc=%h depth=%0d err=%b, want pc=%h depth=%0d err=%b",
                  e.name, pc, depth, stack_err, e.pc, e.dep, e.err);
      end
      rst_n = 1'b1;
      for (int i = 1; i <= 4; i++)
         tv.push_back(mk(J_NONE, 12'hABC, 0, 0, 0, 0, 12'(i), 4'd0, 1'b0, "seq_increment"));
      foreach (tv[i]) begin
         sb.push_back('{tv[i].pc, tv[i].dep, tv[i].err, tv[i].name});
         apply(tv[i]);
         e = sb.pop_front();
         vectors++;
         if ({pc, depth, stack_err} !== {e.pc, e.dep, e.err}) begin
            miscompares++;
            $display("FAIL %s[%0d]: got pc=%h depth=%0d err=%b, want pc=%h depth=%0d err=%b",
                     e.name, i, pc, depth, stack_err, e.pc, e.dep, e.err);
         end
      end
   endtask

   task automatic test_branch();
      vec_t tv[$];
      exp_t e;
      tv.push_back(mk(J_NONE,  12'h000, 1, 1, 0, 0, 12'h005, 4'd0, 1'b0, "flag_load_z"));
      tv.push_back(mk(J_ZERO,  12'h040, 0, 0, 0, 0, 12'h040, 4'd0, 1'b0, "bz_taken"));
      tv.push_back(mk(J_NZERO, 12'h080, 0, 0, 0, 0, 12'h041, 4'd0, 1'b0, "bnz_not_taken"));
      tv.push_back(mk(J_NONE,  12'h000, 1, 0, 1, 0, 12'h042, 4'd0, 1'b0, "flag_load_c"));
      tv.push_back(mk(J_COUT,  12'h300, 0, 0, 0, 0, 12'h300, 4'd0, 1'b0, "bc_taken"));
      tv.push_back(mk(J_NCOUT, 12'h500, 0, 0, 0, 0, 12'h301, 4'd0, 1'b0, "bnc_not_taken"));
      tv.push_back(mk(J_COUT,  12'h600, 1, 1, 0, 0, 12'h600, 4'd0, 1'b0, "old_flag_used"));
      tv.push_back(mk(J_NCOUT, 12'h700, 0, 0, 0, 0, 12'h700, 4'd0, 1'b0, "new_flag_stored"));
      tv.push_back(mk(J_ZERO,  12'h010, 0, 0, 0, 0, 12'h010, 4'd0, 1'b0, "bz_ignores_zero_in"));
      foreach (tv[i]) begin
         sb.push_back('{tv[i].pc, tv[i].dep, tv[i].err, tv[i].name});
         apply(tv[i]);
         e = sb.pop_front();
         vectors++;
         if ({pc, depth, stack_err} !== {e.pc, e.dep, e.err}) begin
            miscompares++;
            $display("FAIL %s: got pc=%h depth=%0d err=%b, want pc=%h depth=%0d err=%b",
                     e.name, pc, depth, stack_err, e.pc, e.dep, e.err);
         end
      end
   endtask

   task automatic test_call_return();
      vec_t tv[$];
      exp_t e;
      tv.push_back(mk(J_JSB, 12'h100, 0, 0, 0, 0, 12'h100, 4'd1, 1'b0, "jsb_1"));
      tv.push_back(mk(J_JSB, 12'h200, 0, 0, 0, 0, 12'h200, 4'd2, 1'b0, "jsb_2"));
      tv.push_back(mk(J_RET, 12'hFFF, 0, 0, 0, 0, 12'h101, 4'd1, 1'b0, "ret_1"));
      tv.push_back(mk(J_RET, 12'hFFF, 0, 0, 0, 0, 12'h011, 4'd0, 1'b0, "ret_2"));
      foreach (tv[i]) begin
         sb.push_back('{tv[i].pc, tv[i].dep, tv[i].err, tv[i].name});
         apply(tv[i]);
         e = sb.pop_front();
         vectors++;
         if ({pc, depth, stack_err} !== {e.pc, e.dep, e.err}) begin
            miscompares++;
            $display("FAIL %s: got pc=%h depth=%0d err=%b, want pc=%h depth=%0d err=%b",
                     e.name, pc, depth, stack_err, e.pc, e.dep, e.err);
         end
      end
   endtask

   task automatic test_stall();
      vec_t tv[$];
      exp_t e;
      tv.push_back(mk(J_JMP,  12'h555, 1, 0, 0, 1, 12'h011, 4'd0, 1'b0, "stall_jmp"));
      tv.push_back(mk(J_JSB,  12'h666, 0, 0, 0, 1, 12'h011, 4'd0, 1'b0, "stall_jsb"));
      tv.push_back(mk(J_ZERO, 12'h050, 0, 0, 0, 0, 12'h050, 4'd0, 1'b0, "flags_held_in_stall"));
      foreach (tv[i]) begin
         sb.push_back('{tv[i].pc, tv[i].dep, tv[i].err, tv[i].name});
         apply(tv[i]);
         e = sb.pop_front();
         vectors++;
         if ({pc, depth, stack_err} !== {e.pc, e.dep, e.err}) begin
            miscompares++;
            $display("FAIL %s: got pc=%h depth=%0d err=%b, want pc=%h depth=%0d err=%b",
                     e.name, pc, depth, stack_err, e.pc, e.dep, e.err);
         end
      end
   endtask

   // From pc 0x050: jsb k targets 0x100+16k and pushes the previous pc+1.
   task automatic test_overflow();
      vec_t tv[$];
      exp_t e;
      for (int k = 0; k < 8; k++)
         tv.push_back(mk(J_JSB, 12'(12'h100 + k * 16), 0, 0, 0, 0, 12'(12'h100 + k * 16),
                         4'(k + 1), 1'b0, "jsb_fill"));
      tv.push_back(mk(J_JSB, 12'h180, 0, 0, 0, 0, GUARD ? 12'h171 : 12'h180, 4'd8, GUARD,
                      "jsb_ninth"));
      for (int j = 0; j < 8; j++) begin
         if (GUARD)
            tv.push_back(mk(J_RET, 12'h000, 0, 0, 0, 0, (j < 7) ? 12'(12'h161 - j * 16) : 12'h051,
                            4'(7 - j), 1'b1, "ret_drain"));
         else
            tv.push_back(mk(J_RET, 12'h000, 0, 0, 0, 0, 12'(12'h171 - j * 16), 4'(7 - j), 1'b0,
                            "ret_drain"));
      end
      tv.push_back(mk(J_RET, 12'h000, 0, 0, 0, 0, GUARD ? 12'h052 : 12'h171, 4'd0, GUARD,
                      "ret_empty"));
      foreach (tv[i]) begin
         sb.push_back('{tv[i].pc, tv[i].dep, tv[i].err, tv[i].name});
         apply(tv[i]);
         e = sb.pop_front();
         vectors++;
         if ({pc, depth, stack_err} !== {e.pc, e.dep, e.err}) begin
            miscompares++;
            $display("FAIL %s[%0d]: got pc=%h depth=%0d err=%b, want pc=%h depth=%0d err=%b",
                     e.name, i, pc, depth, stack_err, e.pc, e.dep, e.err);
         end
      end
   endtask

   task automatic test_wrap();
      vec_t tv[$];
      exp_t e;
      tv.push_back(mk(J_JMP,  12'hFFF, 0, 0, 0, 0, 12'hFFF, 4'd0, GUARD, "jmp_top"));
      tv.push_back(mk(J_NONE, 12'h123, 0, 0, 0, 0, 12'h000, 4'd0, GUARD, "pc_wrap"));
      foreach (tv[i]) begin
         sb.push_back('{tv[i].pc, tv[i].dep, tv[i].err, tv[i].name});
         apply(tv[i]);
         e = sb.pop_front();
         vectors++;
         if ({pc, depth, stack_err} !== {e.pc, e.dep, e.err}) begin
            miscompares++;
            $display("FAIL %s: got pc=%h depth=%0d err=%b, want pc=%h depth=%0d err=%b",
                     e.name, pc, depth, stack_err, e.pc, e.dep, e.err);
         end
      end
   endtask

   task automatic test_async_reset();
      vec_t tv[$];
      exp_t e;
      tv.push_back(mk(J_JSB, 12'h300, 0, 0, 0, 0, 12'h300, 4'd1, GUARD, "pre_jsb_1"));
      tv.push_back(mk(J_JSB, 12'h400, 0, 0, 0, 0, 12'h400, 4'd2, GUARD, "pre_jsb_2"));
      foreach (tv[i]) begin
         sb.push_back('{tv[i].pc, tv[i].dep, tv[i].err, tv[i].name});
         apply(tv[i]);
         e = sb.pop_front();
         vectors++;
         if ({pc, depth, stack_err} !== {e.pc, e.dep, e.err}) begin
            miscompares++;
            $display("FAIL %s: got pc=%h depth=%0d err=%b, want pc=%h depth=%0d err=%b",
                     e.name, pc, depth, stack_err, e.pc, e.dep, e.err);
         end
      end
      // Pulse reset between edges; outputs must clear without waiting for a clock.
      jump_type = J_JSB; target = 12'h700;
      #2;
      rst_n = 1'b0;
      #1;
      sb.push_back('{12'h000, 4'd0, 1'b0, "async_reset_now"});
      e = sb.pop_front();
      vectors++;
      if ({pc, depth, stack_err} !== {e.pc, e.dep, e.err}) begin
         miscompares++;
         $display("FAIL %s: got pc=%h depth=%0d err=%b, want pc=%h depth=%0d err=%b",
                  e.name, pc, depth, stack_err, e.pc, e.dep, e.err);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tv.delete();
      tv.push_back(mk(J_NONE, 12'h000, 0, 0, 0, 0, 12'h001, 4'd0, 1'b0, "post_reset_1"));
      tv.push_back(mk(J_NONE, 12'h000, 0, 0, 0, 0, 12'h002, 4'd0, 1'b0, "post_reset_2"));
`ifdef PC_STACK_GUARD_EN
      tv.push_back(mk(J_RET, 12'h000, 0, 0, 0, 0, 12'h003, 4'd0, 1'b1, "post_reset_ret"));
`endif
      foreach (tv[i]) begin
         sb.push_back('{tv[i].pc, tv[i].dep, tv[i].err, tv[i].name});
         apply(tv[i]);
         e = sb.pop_front();
         vectors++;
         if ({pc, depth, stack_err} !== {e.pc, e.dep, e.err}) begin
            miscompares++;
            $display("FAIL %s: got pc=%h depth=%0d err=%b, want pc=%h depth=%0d err=%b",
                     e.name, pc, depth, stack_err, e.pc, e.dep, e.err);
         end
      end
   endtask

   initial begin
      test_reset();
      test_branch();
      test_call_return();
      test_stall();
      test_overflow();
      test_wrap();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 12, giving the program-counter and target width.
REQ-002 The block SHALL have parameter STACK_DEPTH, default 8 (power of two), giving the number of return-stack entries.
REQ-003 The block SHALL have port clk  input  1  system clock, rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port jump_type  input  3  jump code from the control decoder: 0 none, 1 zero, 2 not-zero, 3 cout, 4 not-cout, 5 jmp, 6 jsb, 7 ret.
REQ-006 The block SHALL have port target  input  ADDR_W  branch/jump/call destination.
REQ-007 The block SHALL have port stall  input  1  hold all state when high.
REQ-008 The block SHALL have port flag_we  input  1  capture zero_in/cout_in this cycle.
REQ-009 The block SHALL have ports zero_in, cout_in  input  1 each  ALU flags.
REQ-010 The block SHALL have port pc  output  ADDR_W  current instruction address.
REQ-011 The block SHALL have port depth  output  log2(STACK_DEPTH)+1  current stack occupancy.
REQ-012 The block SHALL have port stack_err  output  1  sticky overflow/underflow indicator.

Function
REQ-013 Flags zero_q/cout_q SHALL load zero_in/cout_in on a clock edge with flag_we=1 and stall=0; otherwise hold.
REQ-014 Conditional branches (codes 1-4) SHALL test zero_q/cout_q as registered before the edge, never same-cycle zero_in/cout_in.
REQ-015 pc SHALL update every non-stalled edge: pc<=target if taken branch or jmp; pc<=pc+1 if code 0 or not-taken branch; increment wraps modulo 2^ADDR_W.
REQ-016 jsb SHALL push pc+1 (mod 2^ADDR_W) and set pc<=target in the same edge; depth increments by 1.
REQ-017 ret SHALL set pc<=top-of-stack and pop in the same edge; depth decrements by 1.
REQ-018 Latency SHALL be one cycle: the new pc is visible the cycle after jump_type is presented.
REQ-019 stall=1 SHALL freeze pc, flags, stack, depth and stack_err regardless of other inputs.
REQ-020 flag_we together with a conditional branch in the same cycle SHALL use old flags for the decision and store the new ones.
REQ-021 jsb at depth=STACK_DEPTH and ret at depth=0 SHALL follow the REQ-026/REQ-027 behaviour.

Reset
REQ-022 rst_n low SHALL asynchronously force pc=0, depth=0, zero_q=0, cout_q=0, stack_err=0.
REQ-023 Stack entry contents SHALL NOT require reset.
REQ-024 Reset asserted mid-call-chain SHALL discard all return addresses; first fetch after release is address 0.

Configuration
REQ-025 Macro PC_STACK_GUARD_EN SHALL select stack boundary handling.
REQ-026 With PC_STACK_GUARD_EN defined: jsb when full and ret when empty SHALL leave the stack and depth unchanged, set pc<=pc+1, and set stack_err=1 (sticky until reset).
REQ-027 Without PC_STACK_GUARD_EN: the stack SHALL be circular. jsb when full overwrites the oldest entry, with depth saturated at STACK_DEPTH. ret when empty pops the entry at the wrapped pointer, with depth held at 0. stack_err SHALL be tied 0.

Structure
REQ-028 A shared package SHALL hold the jump-type code constants (JT_NONE..JT_RET), the default ADDR_W and the default STACK_DEPTH, also used by the control decoder.
REQ-029 The return stack SHALL be a sub-module ret_stack (push, pop, data in/out, pointer, depth), instantiated once.

Verification
REQ-030 Reset, then 4 cycles of code 0 -> pc sequence 0,1,2,3,4.
REQ-031 flag_we with zero_in=1, next cycle code 1 with target=0x040 -> pc=0x040. Then code 2 with target=0x080 -> pc=0x041.
REQ-032 At pc=0x010, jsb target=0x100, then jsb target=0x200, then ret, then ret -> pc 0x100, 0x200, 0x101, 0x011; depth 1,2,1,0.
REQ-033 Nine consecutive jsb with STACK_DEPTH=8 -> with guard: stack_err=1, depth=8, ninth gives pc+1. Without guard: depth=8 and the first return address is lost.
REQ-034 ret at depth 0 with guard -> pc+1, stack_err=1. stall=1 during jmp -> pc unchanged.
REQ-035 pc=0xFFF with code 0 -> pc=0x000. Asynchronous rst_n pulse mid-cycle -> pc=0 and depth=0 immediately.
